// File: rtl/float_pkg.sv
// Shared float-format constants and the converter state encoding.
// Pure declarations, no logic and no latency.
// Imported by the integer-to-float converter and the downstream float-to-integer stage.
package float_pkg;

    localparam int FLT_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int INT_W    = 16;

    // Exponent for a magnitude whose leading one sits at bit INT_W-1.
    localparam int EXP_TOP  = FLT_BIAS + INT_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/i2f_seq.sv
// Sequential 16-bit integer to IEEE-754 single converter, normalising by one left shift per cycle.
// Latency: 1 cycle for zero, otherwise 2 + (15 - leading-one index) cycles, from accept to o_valid.
// One conversion in flight at a time; o_ready is low until the result is taken, and o_float holds while i_ready is low.
module i2f_seq
    import float_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_integer,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_float,
    output logic        o_busy
);

    state_t             state;
    state_t             state_nxt;
    logic               sign;
    logic [INT_W-1:0]   mag;
    logic [EXP_W-1:0]   exp_q;

    logic               accept;
    logic               in_sign;
    logic [INT_W-1:0]   in_mag;

    // Handshake decode; o_ready is forced low while reset is asserted.
    assign o_ready = (state == IDLE) && !i_rst;
    assign o_busy  = (state == NORM) || (state == DONE);
    assign accept  = i_valid && o_ready;

    // Sign and magnitude of the incoming word; -32768 negates to 0x8000.
    assign in_sign = SIGNED_IN ? i_integer[INT_W-1] : 1'b0;
    assign in_mag  = in_sign ? (~i_integer + 16'd1) : i_integer;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: zero skips normalisation, NORM exits once bit 15 is the leading one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (in_mag == '0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag[INT_W-1]) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, shift-normalise, then pack the result and hold it until taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sign    <= 1'b0;
            mag     <= '0;
            exp_q   <= '0;
            o_valid <= 1'b0;
            o_float <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign  <= in_sign;
                        mag   <= in_mag;
                        exp_q <= EXP_W'(EXP_TOP);
                        if (in_mag == '0) begin
                            // Zero is always encoded as +0.
                            o_float <= '0;
                            o_valid <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    if (mag[INT_W-1]) begin
                        // Hidden bit dropped; 15 fraction bits padded to 23. Always exact.
                        o_float <= {sign, exp_q, mag[INT_W-2:0], 8'h00};
                        o_valid <= 1'b1;
                    end else begin
                        // Exponent bottoms out at FLT_BIAS since mag is nonzero here.
                        mag   <= mag << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2f_seq.sv
// Self-checking bench for i2f_seq: unsigned and signed instances share clock and reset.
// Expected floats come from a double-precision reference; latency from a leading-one count.
// Scoreboard queues hold expectations pushed at accept and popped when o_valid rises.
module tb_i2f_seq;

    logic        clk;
    logic        rst;

    logic        u_valid, u_rdy, u_ovld, u_iready, u_busy;
    logic [15:0] u_int;
    logic [31:0] u_float;
    logic        s_valid, s_rdy, s_ovld, s_iready, s_busy;
    logic [15:0] s_int;
    logic [31:0] s_float;

    int tests;
    int fails;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    i2f_seq #(.SIGNED_IN(1'b0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(u_valid), .o_ready(u_rdy),
        .i_integer(u_int), .o_valid(u_ovld), .i_ready(u_iready),
        .o_float(u_float), .o_busy(u_busy)
    );

    i2f_seq #(.SIGNED_IN(1'b1)) s_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_rdy),
        .i_integer(s_int), .o_valid(s_ovld), .i_ready(s_iready),
        .o_float(s_float), .o_busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: convert via a double and repack into single precision (exact for 16-bit ints).
    function automatic logic [31:0] ref_float(input bit sgn, input logic [15:0] v);
        int          iv;
        real         r;
        logic [63:0] d;
        logic [10:0] e11;
        iv = sgn ? int'($signed(v)) : int'({16'd0, v});
        if (iv == 0) return 32'h0;
        r   = real'(iv);
        d   = $realtobits(r);
        e11 = d[62:52] - 11'd896;
        return {d[63], e11[7:0], d[51:29]};
    endfunction

    function automatic int ref_lat(input bit sgn, input logic [15:0] v);
        int iv;
        int m;
        int p;
        iv = sgn ? int'($signed(v)) : int'({16'd0, v});
        m  = (iv < 0) ? -iv : iv;
        if (m == 0) return 1;
        p = 0;
        for (int b = 0; b < 17; b++) if (m >= (1 << b)) p = b;
        return 2 + 15 - p;
    endfunction

    function automatic logic o_vld(input bit sel);
        return sel ? s_ovld : u_ovld;
    endfunction
    function automatic logic o_rdy(input bit sel);
        return sel ? s_rdy : u_rdy;
    endfunction
    function automatic logic o_bsy(input bit sel);
        return sel ? s_busy : u_busy;
    endfunction
    function automatic logic [31:0] o_flt(input bit sel);
        return sel ? s_float : u_float;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [15:0] d);
        if (sel) begin s_valid = v; s_int = d; end
        else     begin u_valid = v; u_int = d; end
    endtask

    task automatic set_iready(input bit sel, input logic r);
        if (sel) s_iready = r; else u_iready = r;
    endtask

    // Accept one word, wait for o_valid, compare against the scoreboard, and wait until the
    // result can be handed off; with hold_rdy set, i_ready stays low and the caller finishes.
    task automatic run_conv(input bit sel, input logic [15:0] val, input logic [31:0] want,
                            input int want_lat, input bit hold_rdy, input string name);
        int          n;
        bit          seen;
        logic [31:0] ef;
        int          el;
        exp_q.push_back(want);
        lat_q.push_back(want_lat);
        @(negedge clk);
        set_iready(sel, !hold_rdy);
        drive(sel, 1'b1, val);
        tests++;
        if (o_rdy(sel) !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_at_accept: got %b want 1", name, o_rdy(sel));
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 16'h0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            n++;
            @(negedge clk);
            if (o_vld(sel) === 1'b1) seen = 1'b1;
        end
        ef = exp_q.pop_front();
        el = lat_q.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s timeout: o_valid never rose within 40 cycles", name);
        end else begin
            if (o_flt(sel) !== ef) begin
                fails++;
                $display("FAIL %s float: got %h want %h", name, o_flt(sel), ef);
            end
            tests++;
            if (n != el) begin
                fails++;
                $display("FAIL %s latency: got %0d want %0d", name, n, el);
            end
        end
        if (!hold_rdy) begin
            @(posedge clk);
            #1;
            tests++;
            if (o_rdy(sel) !== 1'b1 || o_vld(sel) !== 1'b0 || o_bsy(sel) !== 1'b0) begin
                fails++;
                $display("FAIL %s post_handshake: rdy=%b vld=%b busy=%b want 1 0 0",
                         name, o_rdy(sel), o_vld(sel), o_bsy(sel));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (u_rdy !== 1'b0 || s_rdy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_low: got u=%b s=%b want 0 0", u_rdy, s_rdy);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (u_ovld !== 1'b0 || u_float !== 32'h0 || u_busy !== 1'b0 ||
            s_ovld !== 1'b0 || s_float !== 32'h0 || s_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: u vld=%b flt=%h busy=%b s vld=%b flt=%h busy=%b want 0 0 0",
                     u_ovld, u_float, u_busy, s_ovld, s_float, s_busy);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (u_rdy !== 1'b1 || s_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got u=%b s=%b want 1 1", u_rdy, s_rdy);
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] v;
        run_conv(1'b0, 16'h0001, 32'h3F800000, 17, 1'b0, "u_one");
        run_conv(1'b0, 16'h03E8, 32'h447A0000, 8, 1'b0, "u_1000");
        run_conv(1'b0, 16'h8000, 32'h47000000, 2, 1'b0, "u_8000");
        run_conv(1'b0, 16'hFFFF, ref_float(1'b0, 16'hFFFF), ref_lat(1'b0, 16'hFFFF), 1'b0, "u_ffff");
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom_range(1, 65535));
            run_conv(1'b0, v, ref_float(1'b0, v), ref_lat(1'b0, v), 1'b0, "u_rand");
        end
    endtask

    task automatic test_signed();
        logic [15:0] v;
        run_conv(1'b1, 16'hFFFF, 32'hBF800000, 17, 1'b0, "s_m1");
        run_conv(1'b1, 16'h8000, 32'hC7000000, 2, 1'b0, "s_min");
        run_conv(1'b1, 16'hFC18, 32'hC47A0000, 8, 1'b0, "s_m1000");
        run_conv(1'b1, 16'h7FFF, ref_float(1'b1, 16'h7FFF), ref_lat(1'b1, 16'h7FFF), 1'b0, "s_max");
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom_range(1, 65535));
            run_conv(1'b1, v, ref_float(1'b1, v), ref_lat(1'b1, v), 1'b0, "s_rand");
        end
    endtask

    task automatic test_zero();
        run_conv(1'b0, 16'h0000, 32'h00000000, 1, 1'b0, "u_zero");
        run_conv(1'b1, 16'h0000, 32'h00000000, 1, 1'b0, "s_zero");
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        // Unsigned 3: leading one at bit 1.
        run_conv(1'b0, 16'h0003, 32'h40400000, 16, 1'b1, "bp_conv");
        held = 32'h40400000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (u_float !== held || u_ovld !== 1'b1 || u_rdy !== 1'b0 || u_busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold: flt=%h vld=%b rdy=%b busy=%b want %h 1 0 1",
                         u_float, u_ovld, u_rdy, u_busy, held);
            end
        end
        u_iready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (u_rdy !== 1'b1 || u_ovld !== 1'b0 || u_busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: rdy=%b vld=%b busy=%b want 1 0 0", u_rdy, u_ovld, u_busy);
        end
    endtask

    task automatic test_busy_ignore();
        int stray;
        // Offer a second word throughout NORM; it must not be taken.
        @(negedge clk);
        u_iready = 1'b1;
        drive(1'b0, 1'b1, 16'h0001);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'h8000);
        @(negedge clk);
        tests++;
        if (u_rdy !== 1'b0 || u_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_norm: rdy=%b busy=%b want 0 1", u_rdy, u_busy);
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
        tests++;
        if (u_ovld !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_early: o_valid=%b want 0 (stray word accepted)", u_ovld);
        end
        drive(1'b0, 1'b0, 16'h0);
        stray = 0;
        while (u_ovld !== 1'b1 && stray < 20) begin
            stray++;
            @(negedge clk);
        end
        tests++;
        if (u_float !== 32'h3F800000) begin
            fails++;
            $display("FAIL busy_ignore_result: got %h want 3f800000", u_float);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        u_iready = 1'b1;
        drive(1'b0, 1'b1, 16'h0001);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (u_rdy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ready: got %b want 0", u_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (u_rdy !== 1'b1 || u_ovld !== 1'b0 || u_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_after: rdy=%b vld=%b busy=%b want 1 0 0", u_rdy, u_ovld, u_busy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_ovld !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL rst_mid_discard: o_valid=%b want 0", u_ovld);
                break;
            end
        end
        run_conv(1'b0, 16'h8000, 32'h47000000, 2, 1'b0, "rst_mid_next");
    endtask

    task automatic test_back_to_back();
        run_conv(1'b0, 16'h0100, 32'h43800000, 9, 1'b0, "b2b_a");
        run_conv(1'b0, 16'h0002, 32'h40000000, 16, 1'b0, "b2b_b");
        run_conv(1'b1, 16'hFFFE, 32'hC0000000, 16, 1'b0, "b2b_c");
        run_conv(1'b1, 16'h4000, 32'h46800000, 3, 1'b0, "b2b_d");
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        u_valid  = 1'b0; u_int = 16'h0; u_iready = 1'b1;
        s_valid  = 1'b0; s_int = 16'h0; s_iready = 1'b1;
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
